ibex_multdiv_issue: RTL and testbench
=====================================

Name: ibex_multdiv_issue

Overview:
Request front-end directly upstream of ibex_multdiv_slow, placed inside the EX block. It accepts one MUL/DIV request per valid/ready handshake and latches the operands. It holds mult_en/div_en and the operands stable to the multdiv unit until that unit pulses valid. It then captures the result and presents it downstream with valid/ready. A one-entry result cache returns a repeated identical request in one cycle without engaging the multdiv unit.

Parameters:
CACHE_EN, 1, 1 enables the one-entry result cache; 0 makes every request a miss.
LAT_W, 6, width of the saturating latency counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  abort any in-flight operation and drop any pending response
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&&ready
req_operator_i  in  2  md_op_e: MULL=0, MULH=1, DIV=2, REM=3
req_signed_mode_i  in  2  bit0 = op_a signed, bit1 = op_b signed
req_op_a_i  in  32  operand a
req_op_b_i  in  32  operand b
mult_en_o  out  1  to multdiv mult_en_i
div_en_o  out  1  to multdiv div_en_i
operator_o  out  2  to multdiv operator_i (latched)
signed_mode_o  out  2  to multdiv signed_mode_i (latched)
op_a_o  out  32  to multdiv op_a_i (latched)
op_b_o  out  32  to multdiv op_b_i (latched)
md_valid_i  in  1  from multdiv valid_o
md_result_i  in  32  from multdiv multdiv_result_o
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&&ready
rsp_result_o  out  32  result
rsp_cache_hit_o  out  1  response was served from the cache
rsp_lat_o  out  LAT_W  cycles spent in ISSUE, saturating; 0 on a cache hit

Behaviour:
- Reset: state=IDLE. All outputs 0 except req_ready_o=1. All latches 0. Cache valid=0.
- FSM has three states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready_o=1; mult_en_o=div_en_o=0.
  - On accept, latch operator, signed_mode, op_a and op_b.
  - Hit: CACHE_EN, cache valid, and all four fields equal the cached tag. Next state RESP with the cached result; rsp_cache_hit_o=1, rsp_lat_o=0.
  - Miss: next state ISSUE; latency counter cleared to 0.
- ISSUE:
  - req_ready_o=0.
  - mult_en_o = ~operator_o[1]; div_en_o = operator_o[1]. Both enables are held high through and including the cycle md_valid_i=1.
  - Counter increments each ISSUE cycle and saturates at 2^LAT_W-1.
  - On md_valid_i: capture md_result_i; write the cache (tag = latched fields, data = result, valid=1); next state RESP; rsp_cache_hit_o=0.
  - The enables drop in the cycle after md_valid_i.
  - md_valid_i outside ISSUE is ignored.
- RESP:
  - rsp_valid_o=1; rsp_result_o, rsp_cache_hit_o and rsp_lat_o stay stable until handshake; req_ready_o=0.
  - On rsp_ready_i, next state IDLE.
  - Throughput: one request per (latency + 2) cycles minimum; a hit costs 2 cycles per request.
- Operand/control stability: op_a_o, op_b_o, operator_o and signed_mode_o change only on request accept.
- flush_i (any state): next state IDLE; enables and rsp_valid_o go low the next cycle. The cache is kept, but the in-flight result is never written. Flush wins over a simultaneous md_valid_i, rsp_ready_i or accept in IDLE.
- Divide-by-zero and overflow are handled by the multdiv unit. Its result is passed through and cached unchanged.
- An asynchronous reset mid-operation returns every output and the cache to reset values immediately.

Decomposition:
- ibex_pkg: md_op_e (MD_OP_MULL/MULH/DIV/REM) and the state enum md_issue_state_e.
- One sub-module, ibex_multdiv_result_cache, holds the tag/data/valid registers and produces a combinational hit output.

Test Plan:
The bench uses a multdiv model that asserts md_valid_i 34 cycles after the enable rises.
- MULL 7*6 unsigned -> mult_en_o high for 34 cycles, div_en_o=0; rsp_result_o=42, rsp_cache_hit_o=0, rsp_lat_o=34.
- Repeat the same MULL 7*6 -> mult_en_o stays 0; rsp_valid_o one cycle after accept; result 42, hit=1, lat=0.
- DIV 100/7 signed -> 14, hit=0. Then REM 100/7 (same operands, new operator) -> miss; result 2.
- DIV 5/0 -> result 0xFFFFFFFF from the model and cached. A repeat returns 0xFFFFFFFF with hit=1.
- Raise flush_i at ISSUE cycle 10 of DIV 9/3 -> enables low the next cycle, state IDLE. The cache is unchanged, so a prior entry still hits.
- Hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o and the result stay stable and req_ready_o=0. Deassert rst_ni mid-ISSUE -> all outputs go to reset values, and a repeat of an earlier request misses.

Source files
------------

// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the multdiv issue front-end.
//   md_op_e          - multdiv operator encoding
//   md_issue_state_e - issue front-end FSM states
//   md_req_t         - one latched request (also the result-cache tag)
package ibex_pkg;

   typedef enum logic [1:0] {
      MD_OP_MULL = 2'd0,
      MD_OP_MULH = 2'd1,
      MD_OP_DIV  = 2'd2,
      MD_OP_REM  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE  = 2'd0,
      MD_ISSUE = 2'd1,
      MD_RESP  = 2'd2
   } md_issue_state_e;

   typedef struct packed {
      md_op_e      op;
      logic [1:0]  signed_mode;
      logic [31:0] op_a;
      logic [31:0] op_b;
   } md_req_t;

endpackage

// File: rtl/ibex_multdiv_result_cache.sv
// ibex_multdiv_result_cache: one-entry tag/data store with combinational hit.
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   wr_en          - write wr_tag/wr_data and mark the entry valid
//   wr_tag/wr_data - request fields and the multdiv result to remember
//   lookup         - incoming request fields to compare against the tag
//   hit, data      - entry valid and tag equal; cached result
module ibex_multdiv_result_cache
   import ibex_pkg::*;
#(
   parameter bit CACHE_EN = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        wr_en,
   input  md_req_t     wr_tag,
   input  logic [31:0] wr_data,
   input  md_req_t     lookup,
   output logic        hit,
   output logic [31:0] data
);

   md_req_t     tag_q;
   logic [31:0] data_q;
   logic        valid_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tag_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (wr_en) begin
         tag_q   <= wr_tag;
         data_q  <= wr_data;
         valid_q <= 1'b1;
      end
   end

   assign hit  = CACHE_EN && valid_q && (tag_q == lookup);
   assign data = data_q;

endmodule

// File: rtl/ibex_multdiv_issue.sv
// ibex_multdiv_issue: request front-end for ibex_multdiv_slow with a one-entry result cache.
//   clk_i, rst_ni, flush_i       - clock, async active-low reset, abort in-flight work
//   req_*                        - valid/ready request: operator, signed mode, operands
//   mult_en_o, div_en_o          - enables held to the multdiv unit until md_valid_i
//   operator_o .. op_b_o         - latched request fields, change only on accept
//   md_valid_i, md_result_i      - multdiv completion and result
//   rsp_*                        - valid/ready response: result, cache-hit flag, latency
module ibex_multdiv_issue
   import ibex_pkg::*;
#(
   parameter bit          CACHE_EN = 1'b1,
   parameter int unsigned LAT_W    = 6
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [1:0]       req_operator_i,
   input  logic [1:0]       req_signed_mode_i,
   input  logic [31:0]      req_op_a_i,
   input  logic [31:0]      req_op_b_i,
   output logic             mult_en_o,
   output logic             div_en_o,
   output logic [1:0]       operator_o,
   output logic [1:0]       signed_mode_o,
   output logic [31:0]      op_a_o,
   output logic [31:0]      op_b_o,
   input  logic             md_valid_i,
   input  logic [31:0]      md_result_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [31:0]      rsp_result_o,
   output logic             rsp_cache_hit_o,
   output logic [LAT_W-1:0] rsp_lat_o
);

   md_issue_state_e  state_q, state_d;
   md_req_t          req_in, req_q;
   logic             accept, md_done, cache_hit;
   logic [31:0]      cache_data, result_q;
   logic             hit_q;
   logic [LAT_W-1:0] lat_q;

   assign req_in = '{op: md_op_e'(req_operator_i), signed_mode: req_signed_mode_i,
                     op_a: req_op_a_i, op_b: req_op_b_i};

   assign req_ready_o = (state_q == MD_IDLE);
   // flush suppresses the accept so nothing is latched and no cache lookup commits
   assign accept      = req_valid_i && req_ready_o && !flush_i;
   // a flushed completion must never reach the result register or the cache
   assign md_done     = (state_q == MD_ISSUE) && md_valid_i && !flush_i;

   ibex_multdiv_result_cache #(
      .CACHE_EN(CACHE_EN)
   ) u_cache (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .wr_en  (md_done),
      .wr_tag (req_q),
      .wr_data(md_result_i),
      .lookup (req_in),
      .hit    (cache_hit),
      .data   (cache_data)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= MD_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE:  if (accept)      state_d = cache_hit ? MD_RESP : MD_ISSUE;
         MD_ISSUE: if (md_valid_i)  state_d = MD_RESP;
         MD_RESP:  if (rsp_ready_i) state_d = MD_IDLE;
         default:                   state_d = MD_IDLE;
      endcase
      if (flush_i) state_d = MD_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_q    <= '0;
         result_q <= '0;
         hit_q    <= 1'b0;
         lat_q    <= '0;
      end else begin
         if (accept) begin
            req_q <= req_in;
            hit_q <= cache_hit;
            lat_q <= '0;
            if (cache_hit) result_q <= cache_data;
         end
         // the completion cycle itself is counted, so lat equals the number of enable cycles
         if (state_q == MD_ISSUE && !flush_i) lat_q <= &lat_q ? lat_q : lat_q + 1'b1;
         if (md_done) result_q <= md_result_i;
      end
   end

   assign mult_en_o       = (state_q == MD_ISSUE) && !req_q.op[1];
   assign div_en_o        = (state_q == MD_ISSUE) &&  req_q.op[1];
   assign operator_o      = req_q.op;
   assign signed_mode_o   = req_q.signed_mode;
   assign op_a_o          = req_q.op_a;
   assign op_b_o          = req_q.op_b;
   assign rsp_valid_o     = (state_q == MD_RESP);
   assign rsp_result_o    = result_q;
   assign rsp_cache_hit_o = hit_q;
   assign rsp_lat_o       = lat_q;

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// tb_ibex_multdiv_issue: randomized self-checking bench with a fixed-latency multdiv model.
module tb_ibex_multdiv_issue;

   logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
   logic        req_valid_i = 1'b0, rsp_ready_i = 1'b0;
   logic [1:0]  req_operator_i = '0, req_signed_mode_i = '0;
   logic [31:0] req_op_a_i = '0, req_op_b_i = '0;
   logic        req_ready_o, mult_en_o, div_en_o, md_valid_i, rsp_valid_o, rsp_cache_hit_o;
   logic [1:0]  operator_o, signed_mode_o;
   logic [31:0] op_a_o, op_b_o, md_result_i, rsp_result_o;
   logic [5:0]  rsp_lat_o;
   logic [110:0] outs;

   int errors = 0, checks = 0, en_cnt = 0;
   logic        cache_ok = 1'b0;
   logic [67:0] cache_key = '0;

   ibex_multdiv_issue #(.CACHE_EN(1'b1), .LAT_W(6)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_operator_i(req_operator_i), .req_signed_mode_i(req_signed_mode_i),
      .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
      .mult_en_o(mult_en_o), .div_en_o(div_en_o), .operator_o(operator_o),
      .signed_mode_o(signed_mode_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
      .md_valid_i(md_valid_i), .md_result_i(md_result_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
      .rsp_cache_hit_o(rsp_cache_hit_o), .rsp_lat_o(rsp_lat_o)
   );

   always #5 clk_i = ~clk_i;

   assign outs = {req_ready_o, mult_en_o, div_en_o, operator_o, signed_mode_o, op_a_o, op_b_o,
                  rsp_valid_o, rsp_result_o, rsp_cache_hit_o, rsp_lat_o};

   // reference arithmetic of the multdiv unit (RISC-V M semantics)
   function automatic logic [31:0] md_ref(input logic [1:0] op, input logic [1:0] sm,
                                          input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = sm[0] ? {{32{a[31]}}, a} : {32'd0, a};
      eb = sm[1] ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ea * eb;
      if (!op[1]) return op[0] ? p[63:32] : p[31:0];
      if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
      if (sm[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[0] ? 32'd0 : a;
      if (sm[0]) return op[0] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      return op[0] ? a % b : a / b;
   endfunction

   // multdiv model: valid on the 34th consecutive enabled cycle
   always @(posedge clk_i) en_cnt <= ((mult_en_o || div_en_o) && !md_valid_i) ? en_cnt + 1 : 0;
   assign md_valid_i  = (mult_en_o || div_en_o) && en_cnt == 33;
   assign md_result_i = md_ref(operator_o, signed_mode_o, op_a_o, op_b_o);

   task automatic run_req(input logic [1:0] op, input logic [1:0] sm,
                          input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [31:0] er;
      logic        eh;
      int          cyc, mc, dc;
      er = md_ref(op, sm, a, b);
      eh = cache_ok && cache_key == {op, sm, a, b};
      @(negedge clk_i);
      req_valid_i = 1'b1; req_operator_i = op; req_signed_mode_i = sm;
      req_op_a_i = a; req_op_b_i = b;
      checks++;
      if (req_ready_o !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", req_ready_o); end
      @(negedge clk_i);
      req_valid_i = 1'b0;
      req_op_a_i = $urandom; req_op_b_i = $urandom;
      cyc = 1; mc = 0; dc = 0;
      while (rsp_valid_o !== 1'b1 && cyc < 100) begin
         mc += int'(mult_en_o); dc += int'(div_en_o);
         @(negedge clk_i); cyc++;
      end
      checks++;
      if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL rsp_timeout: got %b want 1", rsp_valid_o); end
      checks++;
      if (cyc != (eh ? 1 : 35)) begin errors++; $display("FAIL rsp_delay: got %0d want %0d", cyc, eh ? 1 : 35); end
      checks++;
      if (rsp_result_o !== er) begin errors++; $display("FAIL result: got %h want %h", rsp_result_o, er); end
      checks++;
      if (rsp_cache_hit_o !== eh) begin errors++; $display("FAIL cache_hit: got %b want %b", rsp_cache_hit_o, eh); end
      checks++;
      if (rsp_lat_o !== (eh ? 6'd0 : 6'd34)) begin errors++; $display("FAIL latency: got %0d want %0d", rsp_lat_o, eh ? 0 : 34); end
      checks++;
      if (mc != ((!eh && !op[1]) ? 34 : 0) || dc != ((!eh && op[1]) ? 34 : 0)) begin
         errors++; $display("FAIL enable_cycles: got mult=%0d div=%0d want op=%0d hit=%b", mc, dc, op, eh);
      end
      checks++;
      if ({operator_o, signed_mode_o, op_a_o, op_b_o} !== {op, sm, a, b}) begin
         errors++; $display("FAIL latched_fields: got %h want %h", {operator_o, signed_mode_o, op_a_o, op_b_o}, {op, sm, a, b});
      end
      checks++;
      if (req_ready_o !== 1'b0) begin errors++; $display("FAIL resp_ready_low: got %b want 0", req_ready_o); end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk_i);
         checks++;
         if ({rsp_valid_o, rsp_result_o, rsp_cache_hit_o, req_ready_o} !== {1'b1, er, eh, 1'b0}) begin
            errors++; $display("FAIL resp_hold: got %h want %h", {rsp_valid_o, rsp_result_o, rsp_cache_hit_o, req_ready_o}, {1'b1, er, eh, 1'b0});
         end
      end
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      checks++;
      if ({rsp_valid_o, req_ready_o} !== 2'b01) begin errors++; $display("FAIL resp_done: got %b want 01", {rsp_valid_o, req_ready_o}); end
      cache_ok = 1'b1; cache_key = {op, sm, a, b};
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (outs !== {1'b1, 110'd0}) begin errors++; $display("FAIL reset_outputs: got %h want %h", outs, {1'b1, 110'd0}); end
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_mul();
      run_req(2'd0, 2'b00, 32'd7, 32'd6, 0);
      run_req(2'd0, 2'b00, 32'd7, 32'd6, 0);
      run_req(2'd1, 2'b11, 32'hFFFF_FFFE, 32'd3, 1);
   endtask

   task automatic test_div();
      run_req(2'd2, 2'b11, 32'd100, 32'd7, 0);
      run_req(2'd3, 2'b11, 32'd100, 32'd7, 0);
      run_req(2'd2, 2'b11, 32'hFFFF_FF9C, 32'd7, 0);
   endtask

   task automatic test_div_zero();
      run_req(2'd2, 2'b11, 32'd5, 32'd0, 0);
      run_req(2'd2, 2'b11, 32'd5, 32'd0, 0);
      run_req(2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
   endtask

   task automatic test_flush();
      logic [67:0] prev;
      prev = cache_key;
      @(negedge clk_i);
      req_valid_i = 1'b1; req_operator_i = 2'd2; req_signed_mode_i = 2'b11;
      req_op_a_i = 32'd9; req_op_b_i = 32'd3;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      for (int i = 1; i < 10; i++) @(negedge clk_i);
      checks++;
      if (div_en_o !== 1'b1) begin errors++; $display("FAIL flush_pre_div_en: got %b want 1", div_en_o); end
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      checks++;
      if ({mult_en_o, div_en_o, rsp_valid_o, req_ready_o} !== 4'b0001) begin
         errors++; $display("FAIL flush_abort: got %b want 0001", {mult_en_o, div_en_o, rsp_valid_o, req_ready_o});
      end
      run_req(prev[67:66], prev[65:64], prev[63:32], prev[31:0], 0);
      run_req(2'd2, 2'b11, 32'd9, 32'd3, 0);
   endtask

   task automatic test_resp_hold();
      run_req(2'd0, 2'b01, 32'h1234_5678, 32'h0000_0100, 5);
      run_req(2'd0, 2'b01, 32'h1234_5678, 32'h0000_0100, 5);
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         if (cache_ok && $urandom_range(0, 2) == 0)
            run_req(cache_key[67:66], cache_key[65:64], cache_key[63:32], cache_key[31:0], $urandom_range(0, 3));
         else
            run_req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom,
                    ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom, $urandom_range(0, 3));
      end
   endtask

   task automatic test_async_reset();
      run_req(2'd0, 2'b00, 32'd7, 32'd6, 0);
      @(negedge clk_i);
      req_valid_i = 1'b1; req_operator_i = 2'd3; req_signed_mode_i = 2'b00;
      req_op_a_i = 32'd50; req_op_b_i = 32'd8;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      repeat (5) @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if (outs !== {1'b1, 110'd0}) begin errors++; $display("FAIL async_reset: got %h want %h", outs, {1'b1, 110'd0}); end
      @(negedge clk_i);
      rst_ni = 1'b1;
      cache_ok = 1'b0;
      run_req(2'd0, 2'b00, 32'd7, 32'd6, 0);
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_flush();
      test_resp_hold();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
